// File: rtl/nibble_swap_arbiter_if.sv
// Valid/ready bundle between two byte requesters, the nibble-swap arbiter and
// its single consumer. The slave modport is the arbiter side.
interface nibble_swap_arbiter_if #(
   parameter int DATA_W = 8
);
   logic              in0_valid;
   logic [DATA_W-1:0] in0_data;
   logic              in0_ready;
   logic              in1_valid;
   logic [DATA_W-1:0] in1_data;
   logic              in1_ready;
   logic              bypass;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_src;
   logic              out_ready;

   modport master (
      output in0_valid, in0_data, in1_valid, in1_data, bypass, out_ready,
      input  in0_ready, in1_ready, out_valid, out_data, out_src
   );

   modport slave (
      input  in0_valid, in0_data, in1_valid, in1_data, bypass, out_ready,
      output in0_ready, in1_ready, out_valid, out_data, out_src
   );
endinterface

// File: rtl/nibble_swap_arbiter.sv
// Two-input round-robin arbiter feeding one registered half-swap stage.
// Optional per-source grant counters are built when SWAP_STATS_EN is defined.
module nibble_swap_arbiter #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   nibble_swap_arbiter_if.slave    bus
`ifdef SWAP_STATS_EN
   ,
   input  logic                    stat_clr,
   output logic [CNT_W-1:0]        cnt0,
   output logic [CNT_W-1:0]        cnt1
`endif
);

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_0    = 2'd1,
      GNT_1    = 2'd2
   } grant_t;

   grant_t            w_grant;
   logic              w_load_en;
   logic              w_accept;
   logic [DATA_W-1:0] w_sel_data;
   logic [DATA_W-1:0] w_swapped;

   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_data;
   logic              r_out_src;
   logic              r_last_grant;

   assign w_load_en = !r_out_valid || bus.out_ready;

   // NOTE: give every always_comb output a default first so no path infers a latch.
   always_comb begin
      w_grant = GNT_NONE;
      if (bus.in0_valid && bus.in1_valid) begin
         w_grant = r_last_grant ? GNT_0 : GNT_1;
      end else if (bus.in0_valid) begin
         w_grant = GNT_0;
      end else if (bus.in1_valid) begin
         w_grant = GNT_1;
      end
   end

   assign w_accept   = w_load_en && (w_grant != GNT_NONE);
   assign w_sel_data = (w_grant == GNT_1) ? bus.in1_data : bus.in0_data;
   assign w_swapped  = {w_sel_data[DATA_W/2-1:0], w_sel_data[DATA_W-1:DATA_W/2]};

   assign bus.in0_ready = w_load_en && (w_grant == GNT_0);
   assign bus.in1_ready = w_load_en && (w_grant == GNT_1);

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_out_src    <= 1'b0;
         r_last_grant <= 1'b1;
      end else if (w_load_en) begin
         if (w_accept) begin
            r_out_data   <= bus.bypass ? w_sel_data : w_swapped;
            r_out_src    <= (w_grant == GNT_1);
            r_out_valid  <= 1'b1;
            r_last_grant <= (w_grant == GNT_1);
         end else begin
            r_out_valid  <= 1'b0;
         end
      end
   end

   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_src   = r_out_src;

`ifdef SWAP_STATS_EN
   logic [CNT_W-1:0] r_cnt0;
   logic [CNT_W-1:0] r_cnt1;

   // Counters saturate at all-ones; clear wins over a same-cycle increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt0 <= '0;
         r_cnt1 <= '0;
      end else if (stat_clr) begin
         r_cnt0 <= '0;
         r_cnt1 <= '0;
      end else if (w_accept) begin
         if (w_grant == GNT_0 && r_cnt0 != '1) r_cnt0 <= r_cnt0 + CNT_W'(1);
         if (w_grant == GNT_1 && r_cnt1 != '1) r_cnt1 <= r_cnt1 + CNT_W'(1);
      end
   end

   assign cnt0 = r_cnt0;
   assign cnt1 = r_cnt1;
`else
   // CNT_W only sizes the statistics counters, which this build omits.
   if (CNT_W < 1) begin : g_cnt_w_unused
   end
`endif

endmodule

// File: tb/tb_nibble_swap_arbiter.sv
// Self-checking bench for nibble_swap_arbiter: directed scenarios plus random
// traffic compared against a cycle-level behavioural model.
module tb_nibble_swap_arbiter;
   localparam int DATA_W = 8;
   localparam int CNT_W  = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   nibble_swap_arbiter_if #(.DATA_W(DATA_W)) bus ();

`ifdef SWAP_STATS_EN
   logic             stat_clr;
   logic [CNT_W-1:0] cnt0;
   logic [CNT_W-1:0] cnt1;
`endif

   nibble_swap_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus)
`ifdef SWAP_STATS_EN
      ,
      .stat_clr (stat_clr),
      .cnt0     (cnt0),
      .cnt1     (cnt1)
`endif
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   // Behavioural model: who won last, what sits in the output slot, counters.
   int m_last;
   bit m_valid;
   int m_data;
   int m_src;
   int m_cnt0;
   int m_cnt1;
   bit m_acc0;
   bit m_acc1;

   task automatic model_reset();
      m_last  = 1;
      m_valid = 0;
      m_data  = 0;
      m_src   = 0;
      m_cnt0  = 0;
      m_cnt1  = 0;
      m_acc0  = 0;
      m_acc1  = 0;
   endtask

   function automatic int swap_nibbles(input int d);
      return (d % 16) * 16 + (d / 16);
   endfunction

   function automatic int pick(input bit v0, input bit v1);
      if (v0 && v1) return (m_last == 0) ? 1 : 0;
      if (v0) return 0;
      if (v1) return 1;
      return -1;
   endfunction

   task automatic drive(input bit v0, input int d0, input bit v1, input int d1,
                        input bit byp, input bit ordy);
      bus.in0_valid = v0;
      bus.in0_data  = d0[DATA_W-1:0];
      bus.in1_valid = v1;
      bus.in1_data  = d1[DATA_W-1:0];
      bus.bypass    = byp;
      bus.out_ready = ordy;
   endtask

   // Entered at posedge+1; inputs are already applied for the coming edge.
   task automatic step();
      int  g;
      bit  ld;
      int  d0, d1, d;
      bit  byp, clr;
      @(negedge clk);
      g   = pick(bus.in0_valid, bus.in1_valid);
      ld  = !m_valid || bus.out_ready;
      d0  = int'(bus.in0_data);
      d1  = int'(bus.in1_data);
      byp = bus.bypass;
`ifdef SWAP_STATS_EN
      clr = stat_clr;
`else
      clr = 1'b0;
`endif
      check("in0_ready", bus.in0_ready, ld && g == 0);
      check("in1_ready", bus.in1_ready, ld && g == 1);
      @(posedge clk);
      m_acc0 = ld && g == 0;
      m_acc1 = ld && g == 1;
      if (clr) begin
         m_cnt0 = 0;
         m_cnt1 = 0;
      end else begin
         if (m_acc0 && m_cnt0 < (1 << CNT_W) - 1) m_cnt0++;
         if (m_acc1 && m_cnt1 < (1 << CNT_W) - 1) m_cnt1++;
      end
      if (ld) begin
         if (g >= 0) begin
            d       = (g == 0) ? d0 : d1;
            m_data  = byp ? d : swap_nibbles(d);
            m_src   = g;
            m_valid = 1;
            m_last  = g;
         end else begin
            m_valid = 0;
         end
      end
      #1;
      check("out_valid", bus.out_valid, m_valid);
      check("out_data", bus.out_data, m_data);
      check("out_src", bus.out_src, m_src);
`ifdef SWAP_STATS_EN
      check("cnt0", cnt0, m_cnt0);
      check("cnt1", cnt1, m_cnt1);
`endif
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
`ifdef SWAP_STATS_EN
      stat_clr = 1'b0;
`endif
      #1;
      model_reset();
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_out_src", bus.out_src, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit v0, v1;
      int d0, d1;

      do_reset();

      // Single requester: swap of 0xA5.
      drive(1, 'hA5, 0, 0, 0, 1);
      step();
      check("t1_data", bus.out_data, 'h5A);

      // Both valid: alternation starting with requester 0.
      do_reset();
      drive(1, 'h12, 1, 'h34, 0, 1);
      for (int i = 0; i < 4; i++) begin
         step();
         check("t2_src_alt", bus.out_src, i % 2);
      end

      // Stall with 0x3C held while in1 waits.
      drive(1, 'hC3, 0, 0, 0, 1);
      step();
      check("t3_load", bus.out_data, 'h3C);
      drive(0, 0, 1, 'h77, 0, 0);
      for (int i = 0; i < 3; i++) step();
      check("t3_held", bus.out_data, 'h3C);
      drive(0, 0, 1, 'h77, 0, 1);
      step();
      check("t3_after", bus.out_data, 'h77);

      // Bypass, then toggle bypass while stalled.
      drive(0, 0, 1, 'hF0, 1, 1);
      step();
      check("t4_bypass", bus.out_data, 'hF0);
      for (int i = 0; i < 4; i++) begin
         drive(1, 'h81, 1, 'h18, i[0], 0);
         step();
      end
      check("t4_held", bus.out_data, 'hF0);

      // Asynchronous reset mid-stream, then restart from requester 0.
      drive(1, 'h9E, 1, 'h4B, 0, 1);
      step();
      step();
      check("t5_pre_rst_valid", bus.out_valid, 1);
      do_reset();
      drive(1, 'h9E, 1, 'h4B, 0, 1);
      step();
      check("t5_first_src", bus.out_src, 0);

      // Random traffic; requesters obey the valid-hold rule.
      v0 = 0; v1 = 0; d0 = 0; d1 = 0;
      for (int i = 0; i < 400; i++) begin
         if (!v0 || m_acc0) begin
            v0 = ($urandom_range(0, 2) != 0);
            d0 = $urandom_range(0, 255);
         end
         if (!v1 || m_acc1) begin
            v1 = ($urandom_range(0, 2) != 0);
            d1 = $urandom_range(0, 255);
         end
         drive(v0, d0, v1, d1, $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
         step();
      end

`ifdef SWAP_STATS_EN
      do_reset();
      for (int i = 0; i < 300; i++) begin
         drive(1, $urandom_range(0, 255), 0, 0, 0, 1);
         step();
      end
      check("cnt0_sat", cnt0, 255);
      check("cnt1_zero", cnt1, 0);
      stat_clr = 1'b1;
      drive(1, 'h11, 0, 0, 0, 1);
      step();
      stat_clr = 1'b0;
      check("cnt0_clr", cnt0, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
